// File: rtl/fir_seq_ctrl.sv
// fir_seq_ctrl: frame sequencer for the FIR core (load, compute, readout).
// Define FIR_SEQ_CYCLE_CNT_EN to add the compute_cycles output.
module fir_seq_ctrl #(
    parameter int N            = 10,
    parameter int SIGNAL_COUNT = 10,
    parameter int DW           = 32,
    parameter int AW           = 32
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic          in_valid,
    input  logic [DW-1:0] in_data,
    output logic          in_ready,
    output logic          out_valid,
    output logic [DW-1:0] out_data,
    input  logic          out_ready,
    output logic [AW-1:0] core_addr,
    output logic [DW-1:0] core_x,
    output logic [1:0]    core_op,
    input  logic [DW-1:0] core_y,
    input  logic          core_done,
`ifdef FIR_SEQ_CYCLE_CNT_EN
    output logic [15:0]   compute_cycles,
`endif
    output logic          busy,
    output logic          frame_done
);

    localparam int CW = $clog2(SIGNAL_COUNT + 1);
    localparam logic [CW-1:0] LAST = CW'(SIGNAL_COUNT - 1);

    localparam logic [1:0] OP_IDLE = 2'b00;
    localparam logic [1:0] OP_LOAD = 2'b01;
    localparam logic [1:0] OP_COMP = 2'b10;
    localparam logic [1:0] OP_READ = 2'b11;

    generate
        if (SIGNAL_COUNT < 1 || N < 1) begin : g_bad_cfg
            $error("fir_seq_ctrl: SIGNAL_COUNT and N must be >= 1");
        end
    endgenerate

    typedef enum logic [2:0] {
        IDLE, LOAD, LOAD_FLUSH, COMPUTE, RD_ADDR, RD_CAP, RD_OUT, FINISH
    } state_e;

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          in_ready_q, in_ready_d;
    logic          out_valid_q, out_valid_d;
    logic [DW-1:0] out_data_q, out_data_d;
    logic [AW-1:0] core_addr_q, core_addr_d;
    logic [DW-1:0] core_x_q, core_x_d;
    logic [1:0]    core_op_q, core_op_d;
    logic          busy_q, busy_d;
    logic          frame_done_q, frame_done_d;

    logic          load_acc;
    logic          out_acc;

    assign load_acc = in_valid && in_ready_q;
    assign out_acc  = out_valid_q && out_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            in_ready_q   <= 1'b0;
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
            core_addr_q  <= '0;
            core_x_q     <= '0;
            core_op_q    <= OP_IDLE;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            in_ready_q   <= in_ready_d;
            out_valid_q  <= out_valid_d;
            out_data_q   <= out_data_d;
            core_addr_q  <= core_addr_d;
            core_x_q     <= core_x_d;
            core_op_q    <= core_op_d;
            busy_q       <= busy_d;
            frame_done_q <= frame_done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:       if (start) state_d = LOAD;
            LOAD:       if (load_acc && cnt_q == LAST) state_d = LOAD_FLUSH;
            LOAD_FLUSH: state_d = COMPUTE;
            COMPUTE:    if (core_done) state_d = RD_ADDR;
            RD_ADDR:    state_d = RD_CAP;
            RD_CAP:     state_d = RD_OUT;
            RD_OUT: begin
                if (out_acc) state_d = (cnt_q == LAST) ? FINISH : RD_ADDR;
            end
            FINISH:     state_d = IDLE;
            default:    state_d = IDLE;
        endcase
    end

    // Output registers are loaded one cycle ahead so they line up with state_q.
    always_comb begin
        cnt_d        = cnt_q;
        in_ready_d   = in_ready_q;
        out_valid_d  = out_valid_q;
        out_data_d   = out_data_q;
        core_addr_d  = core_addr_q;
        core_x_d     = core_x_q;
        core_op_d    = core_op_q;
        frame_done_d = 1'b0;
        busy_d       = (state_d != IDLE);
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    cnt_d      = '0;
                    in_ready_d = 1'b1;
                    core_op_d  = OP_LOAD;
                end
            end
            LOAD: begin
                if (load_acc) begin
                    core_x_d    = in_data;
                    core_addr_d = AW'(cnt_q);
                    cnt_d       = cnt_q + CW'(1);
                    if (cnt_q == LAST) in_ready_d = 1'b0;
                end
            end
            LOAD_FLUSH: core_op_d = OP_COMP;
            COMPUTE: begin
                if (core_done) begin
                    core_op_d   = OP_READ;
                    core_addr_d = '0;
                    cnt_d       = '0;
                end
            end
            RD_CAP: begin
                out_data_d  = core_y;
                out_valid_d = 1'b1;
            end
            RD_OUT: begin
                if (out_acc) begin
                    out_valid_d = 1'b0;
                    cnt_d       = cnt_q + CW'(1);
                    if (cnt_q == LAST) begin
                        core_op_d    = OP_IDLE;
                        core_addr_d  = '0;
                        frame_done_d = 1'b1;
                    end else begin
                        core_addr_d = AW'(cnt_q + CW'(1));
                    end
                end
            end
            default: ;
        endcase
    end

`ifdef FIR_SEQ_CYCLE_CNT_EN
    logic [15:0] ccyc_q, ccyc_d;

    always_comb begin
        ccyc_d = ccyc_q;
        if (state_q == IDLE && start) begin
            ccyc_d = '0;
        end else if (state_q == COMPUTE && ccyc_q != 16'hFFFF) begin
            ccyc_d = ccyc_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) ccyc_q <= '0;
        else       ccyc_q <= ccyc_d;
    end

    assign compute_cycles = ccyc_q;
`endif

    assign in_ready   = in_ready_q;
    assign out_valid  = out_valid_q;
    assign out_data   = out_data_q;
    assign core_addr  = core_addr_q;
    assign core_x     = core_x_q;
    assign core_op    = core_op_q;
    assign busy       = busy_q;
    assign frame_done = frame_done_q;

endmodule
